// File: rtl/traffic_ctrl_timed.sv
// Two-approach intersection controller (main road NS, side road EW).
// Phase lengths are counted in timebase ticks; NS green is held until the
// side-road sensor has registered a request. A flashing-yellow mode overrides
// the normal cycle whenever flash_en is high.
module traffic_ctrl_timed #(
    parameter int unsigned CNT_W          = 8,
    parameter int unsigned NS_GREEN_TICKS = 20,
    parameter int unsigned EW_GREEN_TICKS = 10,
    parameter int unsigned YELLOW_TICKS   = 4,
    parameter int unsigned ALLRED_TICKS   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       ew_req,
    input  logic       flash_en,
    output logic       ns_r,
    output logic       ns_y,
    output logic       ns_g,
    output logic       ew_r,
    output logic       ew_y,
    output logic       ew_g,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        StAllRedA = 3'd0,
        StNsG     = 3'd1,
        StNsY     = 3'd2,
        StAllRedB = 3'd3,
        StEwG     = 3'd4,
        StEwY     = 3'd5,
        StFlash   = 3'd6
    } state_e;

    // Counter reload values: a phase of D ticks counts D-1 down to 0.
    localparam logic [CNT_W-1:0] LdNsG    = CNT_W'(NS_GREEN_TICKS - 1);
    localparam logic [CNT_W-1:0] LdEwG    = CNT_W'(EW_GREEN_TICKS - 1);
    localparam logic [CNT_W-1:0] LdYellow = CNT_W'(YELLOW_TICKS - 1);
    localparam logic [CNT_W-1:0] LdAllRed = CNT_W'(ALLRED_TICKS - 1);

    // Raw bits so the unused code 7 is representable and recoverable.
    logic [2:0]       state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_q, req_d;
    logic             blink_q, blink_d;
    logic             expired;

    assign expired = tick && (cnt_q == '0);

    // State, phase counter, sticky request and blink registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StAllRedA;
            cnt_q   <= LdAllRed;
            req_q   <= 1'b0;
            blink_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            blink_q <= blink_d;
        end
    end

    // Next-state: flash override, then illegal recovery, then timed sequence.
    always_comb begin
        state_d = state_e'(state_q);
        cnt_d   = cnt_q;
        req_d   = req_q | ew_req;
        blink_d = blink_q;

        if (tick && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end

        if (flash_en) begin
            if (state_q != StFlash) begin
                state_d = StFlash;
                blink_d = 1'b0;
            end else if (tick) begin
                blink_d = ~blink_q;
            end
        end else begin
            case (state_q)
                StAllRedA: begin
                    if (expired) begin
                        state_d = StNsG;
                        cnt_d   = LdNsG;
                    end
                end
                StNsG: begin
                    // Green extension: without a request the counter parks at 0.
                    if (expired && req_q) begin
                        state_d = StNsY;
                        cnt_d   = LdYellow;
                    end
                end
                StNsY: begin
                    if (expired) begin
                        state_d = StAllRedB;
                        cnt_d   = LdAllRed;
                    end
                end
                StAllRedB: begin
                    if (expired) begin
                        state_d = StEwG;
                        cnt_d   = LdEwG;
                        req_d   = 1'b0;  // serving EW consumes the request
                    end
                end
                StEwG: begin
                    if (expired) begin
                        state_d = StEwY;
                        cnt_d   = LdYellow;
                    end
                end
                StEwY: begin
                    if (expired) begin
                        state_d = StAllRedA;
                        cnt_d   = LdAllRed;
                    end
                end
                default: begin
                    // FLASH with flash_en low, or the illegal code 7.
                    state_d = StAllRedA;
                    cnt_d   = LdAllRed;
                end
            endcase
        end
    end

    // Lamp decode from registered state only.
    always_comb begin
        ns_r = 1'b0;
        ns_y = 1'b0;
        ns_g = 1'b0;
        ew_r = 1'b0;
        ew_y = 1'b0;
        ew_g = 1'b0;
        case (state_q)
            StNsG: begin
                ns_g = 1'b1;
                ew_r = 1'b1;
            end
            StNsY: begin
                ns_y = 1'b1;
                ew_r = 1'b1;
            end
            StEwG: begin
                ew_g = 1'b1;
                ns_r = 1'b1;
            end
            StEwY: begin
                ew_y = 1'b1;
                ns_r = 1'b1;
            end
            StFlash: begin
                ns_y = blink_q;
                ew_y = blink_q;
            end
            default: begin
                ns_r = 1'b1;
                ew_r = 1'b1;
            end
        endcase
    end

    assign phase = state_q;

endmodule

// File: doc/traffic_ctrl_timed.md
# traffic_ctrl_timed

Parametrised two-approach intersection controller: a main road (NS) and a side road (EW), each with red/yellow/green heads. Phase durations are counted in `tick` periods from a shared timebase strobe. NS green extends until the side-road sensor requests service. A flashing-yellow fault mode is included. The block sits directly below the intersection top level and drives the lamp drivers.

## Interface
- `CNT_W`, 8, width of the phase down-counter; must hold (max duration − 1).
- `NS_GREEN_TICKS`, 20, minimum NS green, in ticks (≥1).
- `EW_GREEN_TICKS`, 10, fixed EW green, in ticks (≥1).
- `YELLOW_TICKS`, 4, yellow duration for both approaches (≥1).
- `ALLRED_TICKS`, 2, all-red clearance duration (≥1).

- `clk`  in  1  clock; reset reset, asynchronous, active-low; clock clk.
- `reset`  in  1  asynchronous active-low reset.
- `tick`  in  1  timebase enable, one-cycle strobe.
- `ew_req`  in  1  side-road vehicle sensor, level or pulse.
- `flash_en`  in  1  fault/maintenance flash mode request.
- `ns_r`, `ns_y`, `ns_g`  out  1 each  NS lamp heads.
- `ew_r`, `ew_y`, `ew_g`  out  1 each  EW lamp heads.
- `phase`  out  3  current state encoding.

## Operation
- States and `phase` codes:
  - ALLRED_A = 0
  - NS_G = 1
  - NS_Y = 2
  - ALLRED_B = 3
  - EW_G = 4
  - EW_Y = 5
  - FLASH = 6
  - Code 7 is illegal and goes to ALLRED_A on the next edge.
- Normal sequence: ALLRED_A → NS_G → NS_Y → ALLRED_B → EW_G → EW_Y → ALLRED_A.
- Counter `cnt`:
  - On every state entry, load `cnt` with (that state's duration − 1).
  - On each `tick` with `cnt` > 0, decrement `cnt`.
  - Expiry is `tick` = 1 while `cnt` = 0.
- Transition on expiry. The one exception is NS_G: it leaves only on expiry with `req_l` = 1. Otherwise it holds with `cnt` = 0 (green extension).
- `req_l` (sticky request):
  - Set on any cycle with `ew_req` = 1.
  - Cleared on the edge that enters EW_G. If the set and the clear coincide, the clear wins.
- FLASH:
  - Entered on the first edge where `flash_en` = 1, from any state, without waiting for `tick`.
  - `blink` is cleared on entry and toggles on each `tick`.
  - While `flash_en` = 0 in FLASH, the next edge enters ALLRED_A with `cnt` reloaded.
- Lamp decode:
  - Lamps decode combinationally from the state register only.
  - Exactly one lamp is on per head in all non-FLASH states.
  - NS_G: `ns_g` and `ew_r`. NS_Y: `ns_y` and `ew_r`. EW_G: `ew_g` and `ns_r`. EW_Y: `ew_y` and `ns_r`. ALLRED_A/B: `ns_r` and `ew_r`.
  - FLASH: `ns_y` = `ew_y` = `blink`; all red and green lamps are off.
- No state ever drives `ns_g`/`ns_y` and `ew_g`/`ew_y` simultaneously, except both yellows in FLASH.

## Timing
- Reset (`reset` = 0), asynchronous and taking effect immediately, including mid-phase:
  - state ALLRED_A, `cnt` = ALLRED_TICKS − 1, `req_l` = 0, `blink` = 0.
  - `ns_r` = `ew_r` = 1, all other lamps 0, `phase` = 0.
- A state of duration D lasts exactly D ticks after its entry edge. The tick that caused the entry is not counted.
- With `tick` held high, D ticks equals D cycles. NS_G with a pending request lasts NS_GREEN_TICKS cycles.
- Late request: `ew_req` arriving after NS_G expiry causes exit on the first tick after `req_l` sets, at least one cycle later.
- Priority at any edge: reset, then `flash_en`, then illegal state, then expiry.
- `flash_en` and expiry in the same cycle go to FLASH.
- FLASH entry and exit latency is 1 cycle, independent of `tick`.

## Test plan
Unless a scenario says otherwise, use NS_GREEN = 3, EW_GREEN = 2, YELLOW = 2, ALLRED = 1.

1. Assert reset mid-EW_G, asynchronously between edges → lamps go all-red at once with `phase` = 0. After release, with `tick` every cycle and `ew_req` high, `phase` reads 0 for 1 cycle, then 1, 1, 1, 2, 2, 3, 4, 4, 5, 5, 0.
2. `ew_req` = 0, `tick` every cycle → `phase` stays at 1 for 50+ cycles; `ns_g` = `ew_r` = 1.
3. One-cycle `ew_req` pulse while in NS_G at cycle 10 → NS_Y on the next tick. Full EW service follows, and NS_G is then re-entered and holds. This confirms `req_l` was cleared.
4. `tick` every 4th cycle, `ew_req` high → NS_G lasts 12 cycles, YELLOW 8, ALLRED 4, EW_G 8.
5. `flash_en` = 1 in EW_G, cycle 1, `tick` every cycle → `phase` = 6 the next edge. `ns_y`/`ew_y` read 0, 1, 0, 1 on successive cycles, all red and green lamps are 0. After `flash_en` drops, the next edge gives `phase` = 0 with both reds on.
6. `flash_en` rising on the same cycle as NS_Y expiry → FLASH, not ALLRED_B. Force `phase` to 7 via the bench → ALLRED_A on the next edge.
